fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 21 ++
 rtl/fetch_fifo2.sv | 55 +++++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned MEM_WORDS_DEFAULT = 32;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

   // One buffered fetch result: instruction word and the byte PC it came from.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   // Redirect targets are word addresses; the low two bits carry no meaning.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory, redirect and decode-side signals of the fetch sequencer.
interface fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic [31:0] mem_addr;
   logic [31:0] mem_instruct;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (
      input  redirect_valid, redirect_addr, mem_instruct, out_ready,
      output mem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output redirect_valid, redirect_addr, mem_instruct, out_ready,
      input  mem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry skid FIFO holding fetched {instr, pc}; head always in e0.
module fetch_fifo2
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t din,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t e0, e1;
   logic         pop_ok, push_ok;

   // A pop on empty is dropped; a push on full is accepted only alongside a pop.
   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);
   assign head    = e0;

   // Entry storage shifts toward e0 on pop; flush only clears the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count == 2'd0) e0 <= din;
               else               e1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through instruction memory,
// buffers returned words in a 2-entry FIFO and honours redirects.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | waiting for start; redirects ignored
//   ST_RUN    | issuing one fetch per cycle while FIFO credit allows
//   ST_DRAIN  | PC past end of memory; delivering what is buffered
//   ST_HALTED | everything delivered; done high until a redirect
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     start,
   output logic     done,
   fetch_if.master  bus
);

   localparam logic [31:0] PC_END = 32'(4 * MEM_WORDS);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  inflight_pc, inflight_pc_nxt;
   logic         inflight, inflight_nxt;
   logic         push, pop, flush, redirect_take;
   logic [1:0]   fifo_count;
   logic [2:0]   occupancy;
   fetch_entry_t head, din;

   assign pop           = bus.out_valid && bus.out_ready;
   assign redirect_take = bus.redirect_valid && (state != ST_IDLE);
   // Slots already promised: buffered + returning next cycle - leaving now.
   assign occupancy     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign din           = '{instr: bus.mem_instruct, pc: inflight_pc};

   assign bus.mem_addr  = pc;
   assign bus.out_valid = (fifo_count != 2'd0);
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;
   assign done          = (state == ST_HALTED);

   // Next-state, PC and issue bookkeeping; a redirect overrides everything.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      inflight_nxt    = 1'b0;
      inflight_pc_nxt = inflight_pc;
      push            = 1'b0;
      flush           = 1'b0;
      if (redirect_take) begin
         flush     = 1'b1;
         pc_nxt    = word_align(bus.redirect_addr);
         state_nxt = ST_RUN;
      end else begin
         push = inflight;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_nxt = ST_RUN;
                  pc_nxt    = RESET_PC;
               end
            end
            ST_RUN: begin
               if (pc >= PC_END) begin
                  state_nxt = ST_DRAIN;
               end else if (occupancy < 3'd2) begin
                  inflight_nxt    = 1'b1;
                  inflight_pc_nxt = pc;
                  pc_nxt          = pc + 32'd4;
               end
            end
            ST_DRAIN: begin
               if ((fifo_count == 2'd0) && !inflight) state_nxt = ST_HALTED;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, PC and in-flight tracking registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         inflight    <= inflight_nxt;
         inflight_pc <= inflight_pc_nxt;
      end
   end

   fetch_fifo2 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .pop   (pop && !redirect_take),
      .flush (flush),
      .head  (head),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle-exact vector table for start-up and stall,
// directed redirect/halt/reset sequences, then random traffic against a
// stream-level model (expected next PC of the delivered instruction stream).
module tb_fetch_sequencer;

   localparam int unsigned MW   = 32;
   localparam logic [31:0] RPC  = 32'h0000_0000;
   localparam logic [31:0] PEND = 32'h0000_0080;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic done;

   int errors = 0;
   int checks = 0;

   logic [31:0] memw [MW];

   fetch_if bus ();

   fetch_sequencer #(.MEM_WORDS(MW), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory: data for the address sampled at an edge.
   always @(posedge clk) begin
      if (bus.mem_addr < PEND) bus.mem_instruct <= memw[bus.mem_addr[6:2]];
      else                     bus.mem_instruct <= 32'hBAD0_0000 ^ bus.mem_addr;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < PEND) return memw[a[6:2]];
      return 32'hBAD0_0000 ^ a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept everything until done; the stream must run first_pc, +4, ... up to PEND.
   task automatic drain_collect(input logic [31:0] first_pc, input string tag);
      logic [31:0] exp;
      exp = first_pc;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (done) break;
         if (bus.out_valid) begin
            chk({tag, " pc"}, bus.out_pc, exp);
            chk({tag, " instr"}, bus.out_instr, mem_word(exp));
            exp = exp + 32'd4;
         end
         tick();
      end
      chk({tag, " stream end"}, exp, PEND);
      chk({tag, " done"}, {31'b0, done}, 32'd1);
      chk({tag, " valid after end"}, {31'b0, bus.out_valid}, 32'd0);
      chk({tag, " addr held"}, bus.mem_addr, PEND);
   endtask

   typedef struct {
      logic        start;
      logic        ready;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_pc;
      bit          m_idle;

      //           start ready valid instr         pc      addr
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h0,  32'h00};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,       32'h0,  32'h00};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,       32'h0,  32'h04};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h1000,    32'h0,  32'h08};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h1000,    32'h0,  32'h08};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h1000,    32'h0,  32'h08};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h1000,    32'h0,  32'h08};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h1000,    32'h0,  32'h08};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h1000,    32'h0,  32'h08};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h1001,    32'h4,  32'h0C};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h1002,    32'h8,  32'h10};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h1003,    32'hC,  32'h14};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h1004,    32'h10, 32'h18};

      for (int i = 0; i < int'(MW); i++) memw[i] = 32'(32'h1000 + i);
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = 32'h0;
      bus.out_ready      = 1'b0;

      tick();
      tick();
      chk("reset valid", {31'b0, bus.out_valid}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      rst = 1'b1;

      // Start-up latency, stall for 5 cycles, then back-to-back delivery.
      for (int i = 0; i < 13; i++) begin
         start         = vecs[i].start;
         bus.out_ready = vecs[i].ready;
         chk($sformatf("vec%0d valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].valid});
         chk($sformatf("vec%0d instr", i), bus.out_instr, vecs[i].instr);
         chk($sformatf("vec%0d pc", i), bus.out_pc, vecs[i].pc);
         chk($sformatf("vec%0d addr", i), bus.mem_addr, vecs[i].addr);
         chk($sformatf("vec%0d done", i), {31'b0, done}, 32'd0);
         tick();
      end
      start = 1'b0;

      // Redirect to a misaligned address with buffered and returning fetches.
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h0000_0043;
      chk("pre-redirect valid", {31'b0, bus.out_valid}, 32'd1);
      tick();
      bus.redirect_valid = 1'b0;
      chk("redirect flush valid", {31'b0, bus.out_valid}, 32'd0);
      chk("redirect addr", bus.mem_addr, 32'h40);
      tick();
      chk("redirect issue valid", {31'b0, bus.out_valid}, 32'd0);
      chk("redirect next addr", bus.mem_addr, 32'h44);
      tick();
      chk("redirect first valid", {31'b0, bus.out_valid}, 32'd1);
      chk("redirect first pc", bus.out_pc, 32'h40);
      chk("redirect first instr", bus.out_instr, 32'h1010);

      drain_collect(32'h40, "run to end");

      // Restart from HALTED at 0x8.
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h8;
      tick();
      bus.redirect_valid = 1'b0;
      chk("halted redirect done", {31'b0, done}, 32'd0);
      drain_collect(32'h8, "rerun");

      // Redirect past the end: RUN, then DRAIN, then HALTED with nothing fetched.
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h100;
      tick();
      bus.redirect_valid = 1'b0;
      chk("oob run valid", {31'b0, bus.out_valid}, 32'd0);
      chk("oob run done", {31'b0, done}, 32'd0);
      chk("oob addr", bus.mem_addr, 32'h100);
      tick();
      chk("oob drain valid", {31'b0, bus.out_valid}, 32'd0);
      chk("oob drain done", {31'b0, done}, 32'd0);
      tick();
      chk("oob halted done", {31'b0, done}, 32'd1);
      chk("oob halted valid", {31'b0, bus.out_valid}, 32'd0);

      // Asynchronous reset in the middle of a stream.
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 32'h0;
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async rst valid", {31'b0, bus.out_valid}, 32'd0);
      chk("async rst addr", bus.mem_addr, RPC);
      chk("async rst pc", bus.out_pc, 32'h0);
      chk("async rst instr", bus.out_instr, 32'h0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post-reset idle valid", {31'b0, bus.out_valid}, 32'd0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("restart valid", {31'b0, bus.out_valid}, 32'd1);
      chk("restart pc", bus.out_pc, RPC);
      chk("restart instr", bus.out_instr, memw[0]);

      // Random traffic against the stream model.
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < int'(MW); i++) memw[i] = $urandom;
      start = 1'b0;
      tick();
      tick();
      rst    = 1'b1;
      m_idle = 1'b1;
      exp_pc = 32'hFFFF_FFFF;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         start              = (cyc == 10) || ($urandom_range(0, 19) == 0);
         bus.out_ready      = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = ($urandom_range(0, 29) == 0);
         bus.redirect_addr  = $urandom_range(0, 4 * MW + 12);
         if (bus.out_valid && bus.out_ready) begin
            chk("rnd in range", {31'b0, (!m_idle && exp_pc < PEND)}, 32'd1);
            chk("rnd pc", bus.out_pc, exp_pc);
            chk("rnd instr", bus.out_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         if (done) begin
            chk("rnd done all delivered", {31'b0, (!m_idle && exp_pc >= PEND)}, 32'd1);
            chk("rnd done valid", {31'b0, bus.out_valid}, 32'd0);
         end
         if (m_idle) begin
            if (start) begin
               m_idle = 1'b0;
               exp_pc = RPC;
            end
         end else if (bus.redirect_valid) begin
            exp_pc = bus.redirect_addr & ~32'd3;
         end
         tick();
      end
      start              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (done) break;
         if (bus.out_valid) begin
            chk("rnd tail pc", bus.out_pc, exp_pc);
            chk("rnd tail instr", bus.out_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         tick();
      end
      chk("rnd final done", {31'b0, done}, 32'd1);
      chk("rnd final stream end", {31'b0, exp_pc >= PEND}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
